// File: rtl/mfp_eic_signal_filter_if.sv
// Interrupt-line bundle between the raw-source side and the EIC signal filter.
`default_nettype none

interface mfp_eic_signal_filter_if #(
  parameter int CHANNELS  = 32,
  parameter int CNT_WIDTH = 4
);
  logic [CHANNELS-1:0]  raw_signal;
  logic [CHANNELS-1:0]  chan_enable;
  logic [CNT_WIDTH-1:0] filter_len;
  logic [CHANNELS-1:0]  signal;
  logic [CHANNELS-1:0]  rise_pulse;
  logic                 busy;

  modport master (
    output raw_signal,
    output chan_enable,
    output filter_len,
    input  signal,
    input  rise_pulse,
    input  busy
  );

  modport slave (
    input  raw_signal,
    input  chan_enable,
    input  filter_len,
    output signal,
    output rise_pulse,
    output busy
  );
endinterface

`default_nettype wire

// File: rtl/mfp_eic_signal_filter.sv
// Synchronises, polarity-normalises and glitch-filters raw interrupt lines so the
// EIC core only ever sees active-high, HCLK-synchronous, stable levels.
`default_nettype none

module mfp_eic_signal_filter #(
  parameter int                  CHANNELS        = 32,
  parameter int                  CNT_WIDTH       = 4,
  parameter logic [CHANNELS-1:0] ACTIVE_LOW_MASK = '0
) (
  input  wire logic              HCLK,
  input  wire logic              HRESETn,
  mfp_eic_signal_filter_if.slave bus
);

  logic [CHANNELS-1:0]  sync1_q;
  logic [CHANNELS-1:0]  sync2_q;
  logic [CHANNELS-1:0]  norm;
  logic [CHANNELS-1:0]  mismatch;
  logic [CHANNELS-1:0]  signal_q;
  logic [CHANNELS-1:0]  signal_d;
  logic [CHANNELS-1:0]  rise_q;
  logic [CHANNELS-1:0]  rise_d;
  logic                 busy_q;
  logic                 busy_d;
  logic [CNT_WIDTH-1:0] leff_m1;

  // Synchroniser resets to each line's idle level so an active-low source held
  // high through reset does not look like a fresh assertion on release.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync1_q <= ACTIVE_LOW_MASK;
      sync2_q <= ACTIVE_LOW_MASK;
    end else begin
      sync1_q <= bus.raw_signal;
      sync2_q <= sync1_q;
    end
  end

  assign norm     = sync2_q ^ ACTIVE_LOW_MASK;
  assign mismatch = (norm ^ signal_q) & bus.chan_enable;

  // A length of zero behaves as one, so the threshold never underflows.
  assign leff_m1 = (bus.filter_len == '0) ? '0 : (bus.filter_len - CNT_WIDTH'(1));

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 sig_d;

    // '>=' lets a shortened filter length release a count that already passed it.
    always_comb begin
      sig_d = signal_q[i];
      cnt_d = '0;
      if (!bus.chan_enable[i]) begin
        sig_d = 1'b0;
      end else if (norm[i] != signal_q[i]) begin
        if (cnt_q >= leff_m1) begin
          sig_d = norm[i];
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign signal_d[i] = sig_d;
  end

  assign rise_d = signal_d & ~signal_q;
  assign busy_d = |mismatch;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      signal_q <= '0;
      rise_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      signal_q <= signal_d;
      rise_q   <= rise_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.signal     = signal_q;
  assign bus.rise_pulse = rise_q;
  assign bus.busy       = busy_q;

endmodule

`default_nettype wire
